signal_tracker_query_arbiter: RTL and testbench
===============================================

// Module: signal_tracker_query_arbiter
// PURPOSE
// - Shares one signal-tracker query port (TimeTest + ValueFind) among NUM_REQ requesters.
// - Arbitrates round-robin, issues one query at a time, waits for data_valid, returns the result.
// - Guards the tracker with an argument range check and a response timeout.
// - Sits between trace/analysis clients and the tracker instance, in the same clock domain.
// PARAMETERS
// - NUM_REQ              4   number of requesters (>=2)
// - TRACKED_SIGNAL_WIDTH 1   width of tracked signal / signal_recall
// - TIMEOUT_CYCLES       16  max WAIT cycles before an error response (>=1)
// - MAX_RECALL           64  largest legal cycles_back argument
// PORTS
// - clk                    in   1        clock
// - rst_n                  in   1        synchronous reset, active-low
// - req_valid              in   NUM_REQ  per-requester query valid
// - req_ready              out  NUM_REQ  one-hot accept; handshake = valid & ready
// - req_kind               in   NUM_REQ  per requester: 0 = TIME_TEST, 1 = VALUE_FIND
// - req_arg                in   NUM_REQ*32  per requester: signed value_in or cycles_back
// - resp_valid             out  NUM_REQ  one-hot response valid to the granted requester
// - resp_ready             in   NUM_REQ  per-requester response accept
// - resp_err               out  1        1 = timeout or out-of-range argument
// - resp_time0/resp_time1  out  32 each  captured time_out[0]/[1] (signed)
// - resp_recall            out  TRACKED_SIGNAL_WIDTH  captured signal_recall
// - value_in               out  32       to tracker; held stable from ISSUE through WAIT
// - recalculate_time       out  1        one-cycle TimeTest strobe
// - cycles_back_to_recall  out  32       to tracker; held stable from ISSUE through WAIT
// - recalculate_back_cycle out  1        one-cycle ValueFind strobe
// - time_out_0/time_out_1  in   32 each  tracker TimeTest results
// - signal_recall          in   TRACKED_SIGNAL_WIDTH  tracker ValueFind result
// - data_valid             in   1        tracker result valid
// BEHAVIOUR
// - Reset (rst_n low at a clk edge): state IDLE, rr pointer 0, all outputs 0 (strobes, ready, resp_*, args).
//   Reset in any state aborts the operation; no response is issued for the aborted query.
// - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Out-of-range path: IDLE -> RESP directly.
// - IDLE
//   - Grant g = first asserted req_valid at or after the rr pointer.
//   - req_ready[g] = 1 combinationally; all other req_ready bits are 0.
//   - On handshake: latch g, kind and arg.
//   - VALUE_FIND with arg < 0 or arg > MAX_RECALL: resp_err = 1, go to RESP, no tracker strobe.
//   - Otherwise go to ISSUE.
// - ISSUE (1 cycle)
//   - Drive value_in or cycles_back_to_recall from the latched arg; the unused arg output stays 0.
//   - Pulse the matching strobe for exactly 1 cycle. Go to WAIT.
// - WAIT
//   - Sample data_valid from the first WAIT cycle onward; data_valid in IDLE, ISSUE or RESP is ignored.
//   - On data_valid: capture time_out_0/1 (TIME_TEST) or signal_recall (VALUE_FIND) into resp_*.
//     The other result fields are 0. resp_err = 0. Go to RESP.
//   - Timeout counter counts WAIT cycles. When it reaches TIMEOUT_CYCLES without data_valid:
//     resp_err = 1, all result fields 0, go to RESP.
//   - data_valid in the same cycle the counter reaches the limit wins: normal response.
// - RESP
//   - resp_valid[g] = 1; resp_* held stable until resp_ready[g]. Other resp_ready bits are ignored.
//   - On accept: go to IDLE, rr pointer = (g+1) mod NUM_REQ.
// - Latency, handshake at cycle T: strobe at T+1; earliest data_valid sampled at T+2;
//   resp_valid at T+3. No new request is accepted until RESP completes.
// - No req_ready in ISSUE, WAIT or RESP. req_valid is not required to stay asserted once accepted.
// - Arithmetic: arg and time_out are 32-bit two's complement. Timeout counter width = $clog2(TIMEOUT_CYCLES+1).
// STRUCTURE
// - Package signal_tracker_pkg:
//   - query_kind_e {TIME_TEST, VALUE_FIND}
//   - arb_state_e {IDLE, ISSUE, WAIT, RESP}
//   - localparam ARG_W = 32
// - Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot grant. Combinational, reusable.
// - Top holds the FSM, latches, timeout counter and the rr pointer.
// TESTING
// - Single request: req0 TIME_TEST arg=5; tracker returns data_valid 2 cycles after strobe
//   with time_out={-3,7} -> value_in=5 and 1-cycle recalculate_time; resp_valid[0];
//   resp_time0=-3, resp_time1=7, resp_err=0.
// - Round-robin: req0..req3 all valid continuously -> grants in order 0,1,2,3,0.
//   req_ready is never asserted for two requesters at once.
// - Range check: req2 VALUE_FIND arg=65 (MAX_RECALL=64) -> no recalculate_back_cycle pulse;
//   resp_valid[2] at T+1; resp_err=1. arg=64 is accepted and issued.
// - Timeout: tracker never asserts data_valid -> resp_err=1 after exactly 16 WAIT cycles.
//   data_valid on WAIT cycle 16 instead -> normal response.
// - Backpressure: resp_ready[1] held low 10 cycles -> resp_* stable; req0 asserted meanwhile is not granted.
// - Reset mid-WAIT: rst_n low 1 cycle -> all outputs 0 next cycle; a later data_valid produces no response.
//   Next grant starts from requester 0.

Source files
------------

// File: rtl/signal_tracker_pkg.sv
// Shared types for the signal-tracker query arbiter: query kinds, FSM states
// and the argument/result width used on the tracker port.
package signal_tracker_pkg;

  localparam int ARG_W = 32;

  typedef enum logic {
    TIME_TEST  = 1'b0,
    VALUE_FIND = 1'b1
  } query_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping around; grant is one-hot or all zero.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PTR_W = $clog2(N);

  logic             found;
  int               idx;
  logic [PTR_W-1:0] slot;

  // NOTE: every variable is given a default before the loop so no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold its value.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    slot  = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      slot = PTR_W'(idx);
      if (!found && req[slot]) begin
        grant[slot] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/signal_tracker_query_arbiter.sv
// Shares one signal-tracker query port among NUM_REQ requesters: round-robin
// grant, one outstanding query, argument range check and response timeout.
module signal_tracker_query_arbiter
  import signal_tracker_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int TRACKED_SIGNAL_WIDTH = 1,
  parameter int TIMEOUT_CYCLES       = 16,
  parameter int MAX_RECALL           = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_kind,
  input  logic [NUM_REQ*ARG_W-1:0]        req_arg,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic                            resp_err,
  output logic [ARG_W-1:0]                resp_time0,
  output logic [ARG_W-1:0]                resp_time1,
  output logic [TRACKED_SIGNAL_WIDTH-1:0] resp_recall,
  output logic [ARG_W-1:0]                value_in,
  output logic                            recalculate_time,
  output logic [ARG_W-1:0]                cycles_back_to_recall,
  output logic                            recalculate_back_cycle,
  input  logic [ARG_W-1:0]                time_out_0,
  input  logic [ARG_W-1:0]                time_out_1,
  input  logic [TRACKED_SIGNAL_WIDTH-1:0] signal_recall,
  input  logic                            data_valid
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e       state, state_next;
  logic [PTR_W-1:0] rr_ptr, sel_idx, grant_idx;
  logic [NUM_REQ-1:0] grant;
  query_kind_e      kind_q, grant_kind;
  logic [ARG_W-1:0] arg_q, grant_arg;
  logic [CNT_W-1:0] wait_cnt;
  logic             handshake, arg_bad, timeout_hit, resp_accept, in_flight;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Decode the one-hot grant into an index and mux out the winner's request.
  always_comb begin
    grant_idx  = '0;
    grant_kind = TIME_TEST;
    grant_arg  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = PTR_W'(i);
        grant_kind = query_kind_e'(req_kind[i]);
        grant_arg  = req_arg[i*ARG_W +: ARG_W];
      end
    end
  end

  assign handshake   = (state == IDLE) && (|grant);
  assign arg_bad     = (grant_kind == VALUE_FIND) &&
                       (($signed(grant_arg) < 0) || ($signed(grant_arg) > MAX_RECALL));
  // wait_cnt holds the number of completed WAIT cycles, so the current one is wait_cnt+1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_accept = (state == RESP) && resp_ready[sel_idx];
  assign in_flight   = (state == ISSUE) || (state == WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (handshake) state_next = arg_bad ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (data_valid || timeout_hit) state_next = RESP;
      RESP:    if (resp_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) ? grant : '0;
    resp_valid = '0;
    if (state == RESP) resp_valid[sel_idx] = 1'b1;
  end

  // Tracker arguments are held for the whole ISSUE..WAIT window; the unused one stays 0.
  assign value_in               = (in_flight && kind_q == TIME_TEST)  ? arg_q : '0;
  assign cycles_back_to_recall  = (in_flight && kind_q == VALUE_FIND) ? arg_q : '0;
  assign recalculate_time       = (state == ISSUE) && (kind_q == TIME_TEST);
  assign recalculate_back_cycle = (state == ISSUE) && (kind_q == VALUE_FIND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      sel_idx     <= '0;
      kind_q      <= TIME_TEST;
      arg_q       <= '0;
      wait_cnt    <= '0;
      resp_err    <= 1'b0;
      resp_time0  <= '0;
      resp_time1  <= '0;
      resp_recall <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (handshake) begin
            sel_idx     <= grant_idx;
            kind_q      <= grant_kind;
            arg_q       <= grant_arg;
            resp_err    <= arg_bad;
            resp_time0  <= '0;
            resp_time1  <= '0;
            resp_recall <= '0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (data_valid) begin
            resp_err <= 1'b0;
            if (kind_q == TIME_TEST) begin
              resp_time0 <= time_out_0;
              resp_time1 <= time_out_1;
            end else begin
              resp_recall <= signal_recall;
            end
          end else if (timeout_hit) begin
            resp_err <= 1'b1;
          end
        end
        RESP: begin
          if (resp_accept) begin
            rr_ptr      <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
            resp_err    <= 1'b0;
            resp_time0  <= '0;
            resp_time1  <= '0;
            resp_recall <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_tracker_query_arbiter.sv
// Directed bench for signal_tracker_query_arbiter: single query, round-robin,
// range check, timeout, backpressure and reset during WAIT.
module tb_signal_tracker_query_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TW      = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0, req_ready, req_kind = '0;
  logic [NUM_REQ*32-1:0] req_arg = '0;
  logic [NUM_REQ-1:0]   resp_valid, resp_ready = '0;
  logic                 resp_err;
  logic [31:0]          resp_time0, resp_time1, value_in, cycles_back_to_recall;
  logic [TW-1:0]        resp_recall, signal_recall = '0;
  logic                 recalculate_time, recalculate_back_cycle;
  logic [31:0]          time_out_0 = '0, time_out_1 = '0;
  logic                 data_valid = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signal_tracker_query_arbiter #(
    .NUM_REQ(NUM_REQ), .TRACKED_SIGNAL_WIDTH(TW), .TIMEOUT_CYCLES(16), .MAX_RECALL(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_arg(req_arg),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .resp_time0(resp_time0), .resp_time1(resp_time1), .resp_recall(resp_recall),
    .value_in(value_in), .recalculate_time(recalculate_time),
    .cycles_back_to_recall(cycles_back_to_recall), .recalculate_back_cycle(recalculate_back_cycle),
    .time_out_0(time_out_0), .time_out_1(time_out_1), .signal_recall(signal_recall),
    .data_valid(data_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic kind, input logic [31:0] arg);
    req_kind[idx]         = kind;
    req_arg[idx*32 +: 32] = arg;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0 || resp_valid !== 4'b0) begin failures++;
      $display("FAIL reset_handshake ready=%b resp_valid=%b exp 0", req_ready, resp_valid); end
    checks++; if (recalculate_time !== 1'b0 || recalculate_back_cycle !== 1'b0) begin failures++;
      $display("FAIL reset_strobes got=%b%b exp 00", recalculate_time, recalculate_back_cycle); end
    checks++; if (value_in !== 32'd0 || cycles_back_to_recall !== 32'd0) begin failures++;
      $display("FAIL reset_args value_in=%0d cycles_back=%0d exp 0", value_in, cycles_back_to_recall); end
    checks++; if (resp_err !== 1'b0 || resp_time0 !== 32'd0 || resp_time1 !== 32'd0 || resp_recall !== '0) begin
      failures++; $display("FAIL reset_resp err=%b t0=%0d t1=%0d rc=%b exp 0", resp_err, resp_time0, resp_time1, resp_recall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 1'b0, 32'd5);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (recalculate_time !== 1'b1 || value_in !== 32'd5 || recalculate_back_cycle !== 1'b0 ||
                  cycles_back_to_recall !== 32'd0) begin failures++;
      $display("FAIL single_issue strobe=%b value_in=%0d vf_strobe=%b cb=%0d exp 1/5/0/0",
               recalculate_time, value_in, recalculate_back_cycle, cycles_back_to_recall); end
    tick();
    checks++; if (recalculate_time !== 1'b0 || value_in !== 32'd5 || req_ready !== 4'b0) begin failures++;
      $display("FAIL single_wait1 strobe=%b value_in=%0d ready=%b exp 0/5/0000", recalculate_time, value_in, req_ready); end
    tick();
    data_valid = 1'b1; time_out_0 = 32'hFFFF_FFFD; time_out_1 = 32'd7;
    checks++; if (resp_valid !== 4'b0) begin failures++;
      $display("FAIL single_early_resp got=%b exp=0000", resp_valid); end
    tick();
    data_valid = 1'b0; time_out_0 = 32'd99; time_out_1 = 32'd99;
    checks++; if (resp_valid !== 4'b0001 || resp_err !== 1'b0) begin failures++;
      $display("FAIL single_resp valid=%b err=%b exp 0001/0", resp_valid, resp_err); end
    checks++; if (resp_time0 !== 32'hFFFF_FFFD || resp_time1 !== 32'd7 || value_in !== 32'd0) begin failures++;
      $display("FAIL single_data t0=%0d t1=%0d value_in=%0d exp -3/7/0", $signed(resp_time0), $signed(resp_time1), value_in); end
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;
    checks++; if (resp_valid !== 4'b0) begin failures++;
      $display("FAIL single_done got=%b exp=0000", resp_valid); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'(10 + i));
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp = 4'(1 << order[n]);
      #1;
      checks++; if (req_ready !== exp) begin failures++;
        $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready, exp); end
      tick();
      checks++; if (req_ready !== 4'b0 || recalculate_time !== 1'b1 || value_in !== 32'(10 + order[n])) begin
        failures++; $display("FAIL rr_issue%0d ready=%b strobe=%b value_in=%0d exp 0000/1/%0d",
                             n, req_ready, recalculate_time, value_in, 10 + order[n]); end
      tick();
      data_valid = 1'b1; time_out_0 = 32'(100 + order[n]); time_out_1 = 32'(200 + order[n]);
      tick();
      data_valid = 1'b0;
      checks++; if (resp_valid !== exp || resp_time0 !== 32'(100 + order[n]) || req_ready !== 4'b0) begin
        failures++; $display("FAIL rr_resp%0d valid=%b t0=%0d ready=%b exp %b/%0d/0000",
                             n, resp_valid, resp_time0, req_ready, exp, 100 + order[n]); end
      resp_ready = 4'hF;
      tick();
      resp_ready = '0;
    end
    req_valid = '0;
  endtask

  task automatic test_range_check();
    set_req(2, 1'b1, 32'd65);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL range_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (recalculate_back_cycle !== 1'b0 || resp_valid !== 4'b0100 || resp_err !== 1'b1 ||
                  cycles_back_to_recall !== 32'd0) begin failures++;
      $display("FAIL range_65 strobe=%b valid=%b err=%b cb=%0d exp 0/0100/1/0",
               recalculate_back_cycle, resp_valid, resp_err, cycles_back_to_recall); end
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    set_req(2, 1'b1, 32'd64);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    checks++; if (recalculate_back_cycle !== 1'b1 || cycles_back_to_recall !== 32'd64 || resp_valid !== 4'b0 ||
                  value_in !== 32'd0) begin failures++;
      $display("FAIL range_64_issue strobe=%b cb=%0d valid=%b value_in=%0d exp 1/64/0000/0",
               recalculate_back_cycle, cycles_back_to_recall, resp_valid, value_in); end
    tick();
    data_valid = 1'b1; signal_recall = 1'b1; time_out_0 = 32'd77;
    tick();
    data_valid = 1'b0; signal_recall = 1'b0;
    checks++; if (resp_valid !== 4'b0100 || resp_err !== 1'b0 || resp_recall !== 1'b1 || resp_time0 !== 32'd0) begin
      failures++; $display("FAIL range_64_resp valid=%b err=%b rc=%b t0=%0d exp 0100/0/1/0",
                           resp_valid, resp_err, resp_recall, resp_time0); end
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    set_req(2, 1'b1, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    checks++; if (recalculate_back_cycle !== 1'b0 || resp_valid !== 4'b0100 || resp_err !== 1'b1) begin
      failures++; $display("FAIL range_neg strobe=%b valid=%b err=%b exp 0/0100/1",
                           recalculate_back_cycle, resp_valid, resp_err); end
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
  endtask

  task automatic test_timeout();
    set_req(1, 1'b0, 32'd9);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    time_out_0 = 32'd55; time_out_1 = 32'd66;
    for (int k = 1; k <= 16; k++) begin
      checks++; if (resp_valid !== 4'b0) begin failures++;
        $display("FAIL timeout_early wait_cycle=%0d valid=%b exp=0000", k, resp_valid); end
      tick();
    end
    checks++; if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_time0 !== 32'd0 || resp_time1 !== 32'd0) begin
      failures++; $display("FAIL timeout_resp valid=%b err=%b t0=%0d t1=%0d exp 0010/1/0/0",
                           resp_valid, resp_err, resp_time0, resp_time1); end
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    for (int k = 1; k <= 15; k++) tick();
    data_valid = 1'b1; time_out_0 = 32'd11; time_out_1 = 32'd22;
    tick();
    data_valid = 1'b0;
    checks++; if (resp_valid !== 4'b0010 || resp_err !== 1'b0 || resp_time0 !== 32'd11 || resp_time1 !== 32'd22) begin
      failures++; $display("FAIL timeout_last_cycle valid=%b err=%b t0=%0d t1=%0d exp 0010/0/11/22",
                           resp_valid, resp_err, resp_time0, resp_time1); end
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
  endtask

  task automatic test_backpressure();
    set_req(1, 1'b0, 32'd3);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    data_valid = 1'b1; time_out_0 = 32'h1234; time_out_1 = 32'h5678;
    tick();
    data_valid = 1'b0; time_out_0 = 32'hDEAD; time_out_1 = 32'hBEEF;
    set_req(0, 1'b0, 32'd1);
    req_valid  = 4'b0001;
    resp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      checks++; if (resp_valid !== 4'b0010 || resp_time0 !== 32'h1234 || resp_time1 !== 32'h5678 ||
                    resp_err !== 1'b0 || req_ready !== 4'b0) begin failures++;
        $display("FAIL backpressure_hold%0d valid=%b t0=%h t1=%h err=%b ready=%b exp 0010/1234/5678/0/0000",
                 c, resp_valid, resp_time0, resp_time1, resp_err, req_ready); end
      tick();
    end
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    checks++; if (resp_valid !== 4'b0 || req_ready !== 4'b0001) begin failures++;
      $display("FAIL backpressure_release valid=%b ready=%b exp 0000/0001", resp_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_wait();
    set_req(3, 1'b0, 32'd8);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    checks++; if (value_in !== 32'd8) begin failures++;
      $display("FAIL midwait_arg got=%0d exp=8", value_in); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (value_in !== 32'd0 || recalculate_time !== 1'b0 || resp_valid !== 4'b0 || resp_err !== 1'b0 ||
                  req_ready !== 4'b0) begin failures++;
      $display("FAIL midwait_reset value_in=%0d strobe=%b valid=%b err=%b ready=%b exp all 0",
               value_in, recalculate_time, resp_valid, resp_err, req_ready); end
    data_valid = 1'b1; time_out_0 = 32'd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (resp_valid !== 4'b0 || resp_time0 !== 32'd0) begin failures++;
        $display("FAIL midwait_stale%0d valid=%b t0=%0d exp 0000/0", c, resp_valid, resp_time0); end
    end
    data_valid = 1'b0;
    req_valid  = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL midwait_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_range_check();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
